// File: rtl/exec_pkg.sv
// Shared types for the ALU issue/writeback slice.
// Opcode enum, CZN flag struct and stage bundles.
package exec_pkg;

  localparam int DATA_W    = 8;
  localparam int REG_IDX_W = 3;

  typedef enum logic [1:0] {
    ADD_FN = 2'b00,
    AND_FN = 2'b01,
    OR_FN  = 2'b10,
    NOP    = 2'b11
  } opcode_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
  } czn_t;

  typedef struct packed {
    opcode_e             op;
    logic [DATA_W-1:0]   in1;
    logic [DATA_W-1:0]   in2;
    logic [REG_IDX_W-1:0] dest;
    logic                flag_we;
  } id_ex_t;

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [REG_IDX_W-1:0] dest;
    logic                 we;
  } ex_wb_t;

endpackage

// File: rtl/czn_flag_reg.sv
// Committed CZN flag register, updated on S1->S2.
// Ports: upd/is_add/res_msb/zc in, flags {N,Z,C} out.
module czn_flag_reg
  import exec_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd,
  input  logic       is_add,
  input  logic       res_msb,
  input  logic [1:0] zc,
  output logic [2:0] flags
);

  czn_t flags_q, flags_d;

  // Logic ops leave carry alone.
  always_comb begin
    flags_d = flags_q;
    if (upd) begin
      flags_d.z = zc[1];
      flags_d.n = res_msb;
      if (is_add) flags_d.c = zc[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage ALU issue (S1) / result (S2) pipeline.
// Ports: in_* upstream, alu_* ext ALU, wb_* writeback, flags; macro CARRY_CHAIN_EN.
module alu_issue_stage
  import exec_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_opcode,
  input  logic [7:0] in_src1,
  input  logic [7:0] in_src2,
  input  logic [7:0] in_imm,
  input  logic       in_use_imm,
  input  logic       in_use_carry,
  input  logic [2:0] in_dest,
  input  logic       in_flag_we,
  output logic [7:0] alu_in1,
  output logic [7:0] alu_in2,
  output logic [1:0] alu_op,
  output logic       alu_c_in,
  input  logic [7:0] alu_out,
  input  logic [2:0] alu_czn,
  output logic       wb_valid,
  input  logic       wb_ready,
  output logic [7:0] wb_data,
  output logic [2:0] wb_dest,
  output logic       wb_we,
  output logic [2:0] flags
);

  id_ex_t s1_q, s1_d;
  ex_wb_t s2_q, s2_d;
  logic   s1_valid_q, s1_valid_d;
  logic   s2_valid_q, s2_valid_d;
  logic   s1_adv;
  logic   accept;
  logic   flag_upd;
  logic   unused_n;

  assign s1_adv   = s1_valid_q &&
                    (!s2_valid_q || wb_ready);
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    unique case (1'b1)
      accept: begin
        s1_valid_d   = 1'b1;
        s1_d.op      = opcode_e'(in_opcode);
        s1_d.in1     = in_src1;
        s1_d.in2     = in_use_imm ? in_imm
                                  : in_src2;
        s1_d.dest    = in_dest;
        s1_d.flag_we = in_flag_we;
      end
      (s1_adv && !accept): s1_valid_d = 1'b0;
      default: ;
    endcase
  end

  // Refill wins over drain, so back-to-back
  // ops keep S2 occupied.
  always_comb begin
    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    unique case (1'b1)
      s1_adv: begin
        s2_valid_d = 1'b1;
        s2_d.data  = alu_out;
        s2_d.dest  = s1_q.dest;
        s2_d.we    = (s1_q.op != NOP);
      end
      (!s1_adv && wb_ready): s2_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_q       <= s2_d;
      s2_valid_q <= s2_valid_d;
    end
  end

`ifdef CARRY_CHAIN_EN
  logic use_carry_q, use_carry_d;

  always_comb begin
    use_carry_d = use_carry_q;
    if (accept) use_carry_d = in_use_carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) use_carry_q <= 1'b0;
    else        use_carry_q <= use_carry_d;
  end

  assign alu_c_in = (s1_q.op == ADD_FN) &&
                    use_carry_q && flags[0];
`else
  logic unused_carry;
  assign unused_carry = in_use_carry;
  assign alu_c_in     = 1'b0;
`endif

  assign flag_upd = s1_adv && s1_q.flag_we &&
                    (s1_q.op != NOP);
  assign unused_n = alu_czn[2];

  czn_flag_reg u_flags (
    .clk     (clk),
    .rst_n   (rst_n),
    .upd     (flag_upd),
    .is_add  (s1_q.op == ADD_FN),
    .res_msb (alu_out[7]),
    .zc      (alu_czn[1:0]),
    .flags   (flags)
  );

  assign alu_in1  = s1_q.in1;
  assign alu_in2  = s1_q.in2;
  assign alu_op   = s1_q.op;
  assign wb_valid = s2_valid_q;
  assign wb_data  = s2_q.data;
  assign wb_dest  = s2_q.dest;
  assign wb_we    = s2_q.we;

endmodule
